// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU/operand encodings, FSM states and decode structs for the control unit.
// Pure declarations: no logic, no latency, no flow control.
package ctrl_pkg;

    localparam logic [3:0] OPC_BR   = 4'b0000;
    localparam logic [3:0] OPC_ADD  = 4'b0001;
    localparam logic [3:0] OPC_AND  = 4'b0101;
    localparam logic [3:0] OPC_NOT  = 4'b1001;
    localparam logic [3:0] OPC_LEA  = 4'b1110;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;
    localparam logic [1:0] ALU_LEA = 2'b11;

    localparam logic [1:0] SRC_IMM = 2'b00;
    localparam logic [1:0] SRC_PC  = 2'b01;
    localparam logic [1:0] SRC_REG = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_BR,
        OP_ADD,
        OP_AND,
        OP_NOT,
        OP_LEA,
        OP_HALT,
        OP_ILL
    } op_cls_t;

    typedef struct packed {
        op_cls_t    op_cls;
        logic [1:0] alu_op;
        logic [1:0] source_sel;
        logic       reg_wr;
    } ctrl_t;

    typedef struct packed {
        logic [2:0] dr;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic [5:0] imm;
    } fields_t;

endpackage

// File: rtl/ctrl_decode.sv
// Instruction decoder: maps ir to an op class, ALU controls and register/immediate fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows ir continuously.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output ctrl_t       ctrl,
    output fields_t     fields
);

    always_comb begin
        ctrl = '{op_cls: OP_ILL, alu_op: ALU_ADD, source_sel: SRC_IMM, reg_wr: 1'b0};
        case (ir[15:12])
            OPC_ADD: begin
                ctrl.op_cls     = OP_ADD;
                ctrl.alu_op     = ALU_ADD;
                ctrl.source_sel = ir[5] ? SRC_IMM : SRC_REG;
                ctrl.reg_wr     = 1'b1;
            end
            OPC_AND: begin
                ctrl.op_cls     = OP_AND;
                ctrl.alu_op     = ALU_AND;
                ctrl.source_sel = ir[5] ? SRC_IMM : SRC_REG;
                ctrl.reg_wr     = 1'b1;
            end
            OPC_NOT: begin
                ctrl.op_cls     = OP_NOT;
                ctrl.alu_op     = ALU_NOT;
                ctrl.source_sel = SRC_REG;
                ctrl.reg_wr     = 1'b1;
            end
            OPC_LEA: begin
                ctrl.op_cls     = OP_LEA;
                ctrl.alu_op     = ALU_LEA;
                ctrl.source_sel = SRC_PC;
                ctrl.reg_wr     = 1'b1;
            end
            OPC_BR:   ctrl.op_cls = OP_BR;
            OPC_HALT: ctrl.op_cls = OP_HALT;
            default:  ctrl.op_cls = OP_ILL;
        endcase
    end

    assign fields = '{dr: ir[11:9], sr1: ir[8:6], sr2: ir[2:0], imm: ir[5:0]};

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer; CTRL_TRAP_ILLEGAL_EN turns illegal opcodes into a halt trap.
// Latency: 3 cycles per instruction (fetch, decode, exec) plus any imem wait cycles.
// Backpressure: fetch request held with a stable address until imem_valid; valid ignored outside fetch.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W = 6,
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [IR_W-1:0] imem_rdata,
    output logic [1:0]      alu_op,
    output logic [1:0]      source_sel,
    output logic [5:0]      ins_immediate,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      reg_dr,
    output logic [2:0]      reg_sr1,
    output logic [2:0]      reg_sr2,
    output logic            reg_we,
    input  logic            negative,
    input  logic            zero,
    input  logic            positive,
    output logic [2:0]      nzp,
    output logic            halted,
    output logic            illegal_op
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [2:0]      nzp_q, nzp_d;
    ctrl_t           ctrl;
    fields_t         fields;
    logic [PC_W-1:0] br_off;
`ifdef CTRL_TRAP_ILLEGAL_EN
    logic            illegal_q, illegal_d;
`endif

    ctrl_decode u_decode (
        .ir     (ir_q[15:0]),
        .ctrl   (ctrl),
        .fields (fields)
    );

    // Branch offset is a 6-bit two's complement value, sign-extended to the pc width.
    assign br_off = PC_W'(32'(signed'(fields.imm)));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        nzp_d      = nzp_q;
        reg_we     = 1'b0;
        alu_op     = ALU_ADD;
        source_sel = SRC_IMM;
`ifdef CTRL_TRAP_ILLEGAL_EN
        illegal_d  = illegal_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                alu_op     = ctrl.alu_op;
                source_sel = ctrl.source_sel;
                reg_we     = ctrl.reg_wr;
                state_d    = ST_FETCH;
                if (ctrl.reg_wr) begin
                    nzp_d = {negative, zero, positive};
                end
                case (ctrl.op_cls)
                    OP_BR: begin
                        // The condition mask shares the dr field position.
                        if (|(fields.dr & nzp_q)) begin
                            pc_d = pc_q + br_off;
                        end
                    end
                    OP_HALT: state_d = ST_HALT;
                    OP_ILL: begin
`ifdef CTRL_TRAP_ILLEGAL_EN
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
`endif
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            nzp_q   <= 3'b010;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            nzp_q   <= nzp_d;
        end
    end

`ifdef CTRL_TRAP_ILLEGAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // Gated by rst_n so the request is low throughout reset yet rises as soon as reset releases.
    assign imem_req      = (state_q == ST_FETCH) && rst_n;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign nzp           = nzp_q;
    assign halted        = (state_q == ST_HALT);
    assign reg_dr        = fields.dr;
    assign reg_sr1       = fields.sr1;
    assign reg_sr2       = fields.sr2;
    assign ins_immediate = fields.imm;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed expectations checked with immediate assertions.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [5:0] imem_addr;
    logic       imem_valid;
    logic [15:0] imem_rdata;
    logic [1:0] alu_op;
    logic [1:0] source_sel;
    logic [5:0] ins_immediate;
    logic [5:0] pc;
    logic [2:0] reg_dr, reg_sr1, reg_sr2;
    logic       reg_we;
    logic       negative, zero, positive;
    logic [2:0] nzp;
    logic       halted;
    logic       illegal_op;

    int checks = 0;
    int passes = 0;
    int we_cnt = 0;
    int w0;

    control_unit #(.PC_W(6), .IR_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .alu_op        (alu_op),
        .source_sel    (source_sel),
        .ins_immediate (ins_immediate),
        .pc            (pc),
        .reg_dr        (reg_dr),
        .reg_sr1       (reg_sr1),
        .reg_sr2       (reg_sr2),
        .reg_we        (reg_we),
        .negative      (negative),
        .zero          (zero),
        .positive      (positive),
        .nzp           (nzp),
        .halted        (halted),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Waits (bounded) for a fetch request, then returns ins in one cycle; ends at the DECODE negedge.
    task automatic fetch(input string tag, input logic [15:0] ins);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        imem_valid = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        {negative, zero, positive} = 3'b000;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req",     imem_req, 0);
        chk("rst_addr",    imem_addr, 0);
        chk("rst_pc",      pc, 0);
        chk("rst_nzp",     nzp, 3'b010);
        chk("rst_we",      reg_we, 0);
        chk("rst_aluop",   alu_op, 0);
        chk("rst_src",     source_sel, 0);
        chk("rst_halted",  halted, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_dr",      reg_dr, 0);
        chk("rst_imm",     ins_immediate, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_req",  imem_req, 1);
        chk("rel_addr", imem_addr, 0);

        // ADD r1,r1,#-1 with flags 100
        w0 = we_cnt;
        {negative, zero, positive} = 3'b100;
        fetch("add", 16'h127F);
        chk("add_dec_pc",  pc, 1);
        chk("add_dec_we",  reg_we, 0);
        chk("add_dec_req", imem_req, 0);
        @(negedge clk);
        chk("add_ex_we",  reg_we, 1);
        chk("add_ex_alu", alu_op, 2'b00);
        chk("add_ex_src", source_sel, 2'b00);
        chk("add_ex_dr",  reg_dr, 1);
        chk("add_ex_sr1", reg_sr1, 1);
        chk("add_ex_sr2", reg_sr2, 7);
        chk("add_ex_imm", ins_immediate, 6'h3F);
        chk("add_ex_nzp", nzp, 3'b010);
        @(negedge clk);
        chk("add_nzp",    nzp, 3'b100);
        chk("add_pc",     pc, 1);
        chk("add_addr",   imem_addr, 1);
        chk("add_pulses", we_cnt - w0, 1);
        chk("add_f_alu",  alu_op, 0);
        chk("add_f_src",  source_sel, 0);

        // BRz -2 at pc 0, nzp 010: 1 - 2 wraps to 63
        do_reset();
        {negative, zero, positive} = 3'b000;
        fetch("brz", 16'h043E);
        @(negedge clk);
        chk("brz_ex_we", reg_we, 0);
        @(negedge clk);
        chk("brz_pc",   pc, 63);
        chk("brz_addr", imem_addr, 63);
        chk("brz_nzp",  nzp, 3'b010);
        fetch("brnv", 16'h0000);
        chk("wrap_pc", pc, 0);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_addr", imem_addr, 0);

        // Five wait cycles before LEA r2,#5
        w0 = we_cnt;
        {negative, zero, positive} = 3'b001;
        for (int i = 0; i < 5; i++) begin
            chk("wait_req",  imem_req, 1);
            chk("wait_addr", imem_addr, 0);
            chk("wait_we",   reg_we, 0);
            @(negedge clk);
        end
        fetch("lea", 16'hE405);
        chk("lea_dec_pc", pc, 1);
        @(negedge clk);
        chk("lea_alu",   alu_op, 2'b11);
        chk("lea_src",   source_sel, 2'b01);
        chk("lea_imm",   ins_immediate, 6'b000101);
        chk("lea_dr",    reg_dr, 2);
        chk("lea_we",    reg_we, 1);
        chk("wait_nope", we_cnt - w0, 0);
        @(negedge clk);
        chk("lea_nzp",    nzp, 3'b001);
        chk("lea_pulses", we_cnt - w0, 1);

        // Illegal opcode 0011 at pc 1
        fetch("ill", 16'h3000);
        @(negedge clk);
        chk("ill_ex_we", reg_we, 0);
        @(negedge clk);
`ifdef CTRL_TRAP_ILLEGAL_EN
        chk("ill_halted",  halted, 1);
        chk("ill_flag",    illegal_op, 1);
        chk("ill_req",     imem_req, 0);
        imem_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("ill_req_hold", imem_req, 0);
        chk("ill_pc_hold",  pc, 2);
        chk("ill_halt_hold", halted, 1);
        imem_valid = 1'b0;
`else
        chk("ill_req",    imem_req, 1);
        chk("ill_addr",   imem_addr, 2);
        chk("ill_halted", halted, 0);
        chk("ill_flag",   illegal_op, 0);
        chk("ill_nzp",    nzp, 3'b001);
`endif

        // Reset pulse during EXEC of ADD
        do_reset();
        {negative, zero, positive} = 3'b100;
        w0 = we_cnt;
        fetch("radd", 16'h127F);
        @(negedge clk);
        chk("radd_ex_we", reg_we, 1);
        rst_n = 1'b0;
        #1;
        chk("radd_we",  reg_we, 0);
        chk("radd_pc",  pc, 0);
        chk("radd_nzp", nzp, 3'b010);
        chk("radd_req", imem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("radd_pulses", we_cnt - w0, 0);
        chk("radd_nzp2",   nzp, 3'b010);
        chk("radd_refetch_req",  imem_req, 1);
        chk("radd_refetch_addr", imem_addr, 0);

        // AND r3,r1,r2 (register operand)
        {negative, zero, positive} = 3'b001;
        fetch("and", 16'h5642);
        @(negedge clk);
        chk("and_alu", alu_op, 2'b01);
        chk("and_src", source_sel, 2'b10);
        chk("and_dr",  reg_dr, 3);
        chk("and_sr1", reg_sr1, 1);
        chk("and_sr2", reg_sr2, 2);
        @(negedge clk);
        chk("and_nzp", nzp, 3'b001);

        // NOT r4,r3 (ir[5]=1 must still select register)
        {negative, zero, positive} = 3'b100;
        fetch("not", 16'h98FF);
        @(negedge clk);
        chk("not_alu", alu_op, 2'b10);
        chk("not_src", source_sel, 2'b10);
        chk("not_we",  reg_we, 1);
        @(negedge clk);
        chk("not_nzp", nzp, 3'b100);
        chk("not_pc",  pc, 2);

        // HALT
        fetch("halt", 16'hF000);
        @(negedge clk);
        chk("halt_ex_we", reg_we, 0);
        @(negedge clk);
        chk("halt_halted",  halted, 1);
        chk("halt_req",     imem_req, 0);
        chk("halt_pc",      pc, 3);
        chk("halt_illegal", illegal_op, 0);
        imem_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("halt_stay", halted, 1);
        chk("halt_pc2",  pc, 3);
        imem_valid = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
